// File: rtl/cache_cwf.sv
// Direct-mapped read-only cache with critical-word-first line fill.
// Per-word valids allow hits on already-arrived words while a fill runs.
module cache_cwf #(
  parameter int AW      = 32,
  parameter int LINE_W  = 4,
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_valid,
  output logic             cpu_ready,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [1:0]       cpu_size,
  output logic [31:0]      cpu_rdata,
  input  logic             flush,
  output logic             busy,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [AW-1:0]    mem_addr,
  output logic [1:0]       mem_size,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int WW    = LINE_W - 2;
  localparam int TW    = AW - LINE_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << WW;
  localparam int DW    = INDEX_W + WW;

  typedef enum logic {IDLE, FILL} state_e;

  state_e             state_q, state_d;
  logic [WW-1:0]      cnt_q, cnt_d;
  logic [WW-1:0]      crit_q;
  logic [TW-1:0]      fill_tag_q;
  logic [INDEX_W-1:0] fill_idx_q;
  logic               flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [TW-1:0]      tag_q    [LINES];
  logic [WORDS-1:0]   wvalid_q [LINES];
  logic [31:0]        data_q   [1 << DW];

  logic [TW-1:0]      a_tag;
  logic [INDEX_W-1:0] a_idx;
  logic [WW-1:0]      a_wrd;
  logic [WW-1:0]      cnt_nx;
  logic               hit;
  logic               miss_act;
  logic               crit_beat;
  logic               fill_beat;
  logic               last_beat;
  logic               flush_clr;
  logic               hit_inc;
  logic               miss_inc;

  function automatic logic [31:0] fmt(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic [1:0]  sz
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   fmt = {{24{b[7]}}, b};
      2'b01:   fmt = {{16{h[15]}}, h};
      default: fmt = w;
    endcase
  endfunction

  assign a_tag = cpu_addr[AW-1:LINE_W+INDEX_W];
  assign a_idx = cpu_addr[LINE_W+INDEX_W-1:LINE_W];
  assign a_wrd = cpu_addr[LINE_W-1:2];
  assign cnt_nx = cnt_q + WW'(1);

  assign hit = (tag_q[a_idx] == a_tag) && wvalid_q[a_idx][a_wrd];
  assign miss_act  = (state_q == IDLE) && cpu_valid && !hit;
  assign crit_beat = miss_act && mem_ready;
  assign fill_beat = (state_q == FILL) && mem_ready;
  assign last_beat = fill_beat && (cnt_nx == crit_q);

  // A flush raised while a miss or fill is active waits for the fill end
  assign flush_clr =
    ((state_q == IDLE) && !miss_act && (flush || flush_pend_q)) ||
    (last_beat && (flush || flush_pend_q));
  assign flush_pend_d = flush_clr ? 1'b0 : (flush_pend_q | flush);

  assign hit_inc  = cpu_valid && cpu_ready && hit;
  assign miss_inc = crit_beat;
  assign hit_cnt_d  = hit_cnt_q + CNT_W'(hit_inc && !(&hit_cnt_q));
  assign miss_cnt_d = miss_cnt_q + CNT_W'(miss_inc && !(&miss_cnt_q));

  assign busy     = (state_q == FILL) | flush_pend_q;
  assign mem_size = 2'b10;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    if (!rst) begin
      if (cpu_valid && hit) begin
        cpu_ready = 1'b1;
        cpu_rdata = fmt(data_q[{a_idx, a_wrd}], cpu_addr[1:0], cpu_size);
      end else if (miss_act) begin
        mem_valid = 1'b1;
        mem_addr  = {cpu_addr[AW-1:2], 2'b00};
        cpu_ready = mem_ready;
        if (mem_ready) begin
          cpu_rdata = fmt(mem_rdata, cpu_addr[1:0], cpu_size);
        end
      end
      if (state_q == FILL) begin
        mem_valid = 1'b1;
        mem_addr  = {fill_tag_q, fill_idx_q, cnt_q, 2'b00};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (crit_beat) begin
          state_d = FILL;
          cnt_d   = a_wrd + WW'(1);
        end
      end
      FILL: begin
        if (fill_beat) cnt_d = cnt_nx;
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      crit_q       <= '0;
      fill_tag_q   <= '0;
      fill_idx_q   <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      if (crit_beat) begin
        crit_q     <= a_wrd;
        fill_tag_q <= a_tag;
        fill_idx_q <= a_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]    <= '0;
        wvalid_q[i] <= '0;
      end
    end else begin
      if (miss_act) tag_q[a_idx] <= a_tag;
      if (flush_clr) begin
        for (int i = 0; i < LINES; i++) wvalid_q[i] <= '0;
      end else begin
        if (miss_act) begin
          wvalid_q[a_idx] <= '0;
          if (mem_ready) wvalid_q[a_idx][a_wrd] <= 1'b1;
        end
        if (fill_beat) wvalid_q[fill_idx_q][cnt_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (crit_beat) data_q[{a_idx, a_wrd}] <= mem_rdata;
    if (fill_beat) data_q[{fill_idx_q, cnt_q}] <= mem_rdata;
  end

endmodule

// File: tb/tb_cache_cwf.sv
// Directed bench for cache_cwf: critical-word-first fill, hits during
// fill, sub-word formatting, flush, stall on other-line miss, reset.
module tb_cache_cwf;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_rdata;
  logic        flush;
  logic        busy;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  cache_cwf dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_valid (cpu_valid),
    .cpu_ready (cpu_ready),
    .cpu_addr  (cpu_addr),
    .cpu_size  (cpu_size),
    .cpu_rdata (cpu_rdata),
    .flush     (flush),
    .busy      (busy),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_size  (mem_size),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h100) return 32'h8081_8283;
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  assign mem_rdata = memw(mem_addr);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [31:0] a,
                     input logic [1:0] sz, input logic mr);
    cpu_valid = v;
    cpu_addr  = a;
    cpu_size  = sz;
    mem_ready = mr;
    #1;
  endtask

  logic [31:0] rd_addr [5];
  logic [1:0]  rd_size [5];
  logic [31:0] rd_exp  [5];

  initial begin
    rd_addr = '{32'h103, 32'h100, 32'h102, 32'h101, 32'h100};
    rd_size = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    rd_exp  = '{32'hFFFF_FF80, 32'hFFFF_8283, 32'hFFFF_8081,
                32'hFFFF_FF82, 32'h8081_8283};

    rst = 1'b1;
    cpu_valid = 1'b0;
    cpu_addr = '0;
    cpu_size = 2'b10;
    flush = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cpu_ready, 0);
    chk("rst_mvalid", mem_valid, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hits", hit_cnt, 0);
    chk("rst_miss", miss_cnt, 0);
    chk("mem_size", mem_size, 2);
    rst = 1'b0;
    tick();

    req(1, 32'h100, 2, 1);
    chk("c1_mvalid", mem_valid, 1);
    chk("c1_maddr", mem_addr, 32'h100);
    chk("c1_ready", cpu_ready, 1);
    chk("c1_rdata", cpu_rdata, 32'h8081_8283);
    tick();
    req(0, 0, 2, 0);
    chk("c1_busy", busy, 1);
    chk("c1_miss", miss_cnt, 1);
    for (int k = 0; k < 3; k++) begin
      req(0, 0, 2, 1);
      chk("c1_fill_addr", mem_addr, 32'h104 + 4 * k);
      tick();
    end
    req(0, 0, 2, 0);
    chk("c1_idle", busy, 0);
    req(1, 32'h104, 2, 0);
    chk("h104_ready", cpu_ready, 1);
    chk("h104_data", cpu_rdata, memw(32'h104));
    chk("h104_mvalid", mem_valid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      req(1, rd_addr[i], rd_size[i], 0);
      chk("fmt_ready", cpu_ready, 1);
      chk("fmt_data", cpu_rdata, rd_exp[i]);
      tick();
    end
    req(0, 0, 2, 0);
    chk("hits_6", hit_cnt, 6);

    req(1, 32'h20C, 2, 1);
    chk("c2_maddr", mem_addr, 32'h20C);
    chk("c2_ready", cpu_ready, 1);
    chk("c2_rdata", cpu_rdata, memw(32'h20C));
    tick();
    req(0, 0, 2, 1);
    chk("c2_wrap", mem_addr, 32'h200);
    tick();
    req(1, 32'h200, 2, 1);
    chk("c2_beat204", mem_addr, 32'h204);
    chk("fillhit_ready", cpu_ready, 1);
    chk("fillhit_data", cpu_rdata, memw(32'h200));
    tick();
    req(1, 32'h208, 2, 0);
    chk("stall_ready", cpu_ready, 0);
    chk("stall_mvalid", mem_valid, 1);
    tick();
    req(1, 32'h208, 2, 1);
    chk("inflight_addr", mem_addr, 32'h208);
    chk("inflight_ready", cpu_ready, 0);
    tick();
    req(1, 32'h208, 2, 0);
    chk("after_ready", cpu_ready, 1);
    chk("after_data", cpu_rdata, memw(32'h208));
    chk("after_busy", busy, 0);
    tick();
    req(0, 0, 2, 0);
    chk("hits_8", hit_cnt, 8);
    chk("miss_2", miss_cnt, 2);

    req(1, 32'h300, 2, 1);
    chk("c3_ready", cpu_ready, 1);
    tick();
    flush = 1'b1;
    req(0, 0, 2, 0);
    chk("fl_busy", busy, 1);
    tick();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req(0, 0, 2, 1);
      chk("fl_fill_addr", mem_addr, 32'h304 + 4 * k);
      tick();
    end
    req(0, 0, 2, 0);
    chk("fl_done_busy", busy, 0);
    req(1, 32'h30C, 2, 0);
    chk("fl_miss30c", cpu_ready, 0);
    req(1, 32'h300, 2, 0);
    chk("fl_miss300", cpu_ready, 0);
    chk("fl_mvalid", mem_valid, 1);
    chk("fl_maddr", mem_addr, 32'h300);

    req(1, 32'h300, 2, 1);
    chk("c4_ready", cpu_ready, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      req(1, 32'h310, 2, 1);
      chk("other_stall", cpu_ready, 0);
      chk("other_addr", mem_addr, 32'h304 + 4 * k);
      tick();
    end
    req(1, 32'h310, 2, 1);
    chk("c5_maddr", mem_addr, 32'h310);
    chk("c5_ready", cpu_ready, 1);
    chk("c5_rdata", cpu_rdata, memw(32'h310));
    tick();
    for (int k = 0; k < 3; k++) begin
      req(0, 0, 2, 1);
      chk("c5_fill", mem_addr, 32'h314 + 4 * k);
      tick();
    end
    req(0, 0, 2, 0);
    chk("miss_5", miss_cnt, 5);
    chk("c5_busy", busy, 0);

    flush = 1'b1;
    req(0, 0, 2, 0);
    tick();
    flush = 1'b0;
    req(1, 32'h310, 2, 0);
    chk("idle_flush", cpu_ready, 0);

    req(1, 32'h314, 2, 1);
    chk("c6_ready", cpu_ready, 1);
    tick();
    req(0, 0, 2, 1);
    tick();
    req(0, 0, 2, 0);
    chk("pre_rst_mv", mem_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_drop_mv", mem_valid, 0);
    chk("rst_drop_busy", busy, 0);
    tick();
    rst = 1'b0;
    req(1, 32'h314, 2, 0);
    chk("post_rst_miss", cpu_ready, 0);
    chk("post_rst_mv", mem_valid, 1);
    chk("post_rst_mcnt", miss_cnt, 0);
    chk("post_rst_hcnt", hit_cnt, 0);
    req(0, 0, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
